// File: rtl/pep_twd_seq_pkg.sv
// Shared types and parameter derivations for the INTT-final twiddle sequencer.
package pep_twd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Number of ROM words per PBS: R**S / (R*PSI).
  function automatic int stg_iter_nb_f(input int r, input int psi, input int s);
    int p;
    p = 1;
    for (int i = 0; i < s; i++) p = p * r;
    return p / (r * psi);
  endfunction

  function automatic int stg_iter_w_f(input int nb);
    return (nb <= 2) ? 1 : $clog2(nb);
  endfunction

  // One slot per in-flight ROM read plus slack for a full-rate pop/push overlap.
  function automatic int depth_f(input int rom_latency);
    return rom_latency + 2;
  endfunction

endpackage

// File: rtl/twiddle_intt_final_seq_fifo.sv
// Small circular-buffer FIFO holding returned twiddle words; exposes its occupancy.
module twiddle_intt_final_seq_fifo #(
  parameter  int DEPTH = 3,
  parameter  int DW    = 2048,
  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    pop_data,
  output logic [OCC_W-1:0] occ
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DW-1:0]    mem_q [2**PTR_W];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Payload storage needs no reset; occ gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign occ      = occ_q;

endmodule

// File: rtl/twiddle_intt_final_seq.sv
// Batch controller for the INTT-final twiddle ROM with credit-controlled prefetch FIFO.
// Build option TWD_INTT_FINAL_SEQ_FREERUN_EN: run forever without commands.
module twiddle_intt_final_seq
  import pep_twd_seq_pkg::*;
#(
  parameter  int OP_W        = 32,
  parameter  int R           = 8,
  parameter  int PSI         = 8,
  parameter  int S           = 3,
  parameter  int ROM_LATENCY = 1,
  parameter  int PBS_NB_W    = 8,
  localparam int STG_ITER_NB = stg_iter_nb_f(R, PSI, S),
  localparam int STG_ITER_W  = stg_iter_w_f(STG_ITER_NB),
  localparam int DW          = PSI * R * OP_W
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic [PBS_NB_W-1:0]   cmd_pbs_nb,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  output logic                  rom_rd_en,
  output logic [STG_ITER_W-1:0] rom_rd_add,
  input  logic [DW-1:0]         rom_rd_data,
  output logic [DW-1:0]         twd_data,
  output logic                  twd_vld,
  input  logic                  twd_rdy,
  output logic                  batch_done,
  output logic                  busy
);

  localparam int DEPTH = depth_f(ROM_LATENCY);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CR_W  = OCC_W + 1;
  localparam int CNT_W = PBS_NB_W + STG_ITER_W;
`ifdef TWD_INTT_FINAL_SEQ_FREERUN_EN
  localparam logic CMD_RDY_RST = 1'b0;
`else
  localparam logic CMD_RDY_RST = 1'b1;
`endif

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
  logic [STG_ITER_W-1:0]  rd_add_q, rd_add_d;
  logic [OCC_W-1:0]       inflight_q, inflight_d;
  logic [ROM_LATENCY-1:0] ret_q, ret_d;
  logic                   batch_done_q, batch_done_d;
  logic                   cmd_rdy_q, cmd_rdy_d;
  logic                   busy_q, busy_d;

  logic [OCC_W-1:0] occ;
  logic             push, pop, credit_ok, issue;

  // Handshakes: cmd and twd transfer on a cycle where both vld and rdy are high;
  // a raised twd_vld holds with stable twd_data until accepted.
  assign twd_vld   = (occ != '0);
  assign pop       = twd_vld & twd_rdy;
  assign push      = ret_q[ROM_LATENCY-1];
  assign credit_ok = ({1'b0, occ} + {1'b0, inflight_q}) < CR_W'(DEPTH);
`ifdef TWD_INTT_FINAL_SEQ_FREERUN_EN
  assign issue     = (state_q == ST_RUN) && credit_ok;
`else
  assign issue     = (state_q == ST_RUN) && (issue_cnt_q != '0) && credit_ok;
`endif

  always_comb begin
    state_d      = state_q;
    batch_done_d = 1'b0;
    issue_cnt_d  = issue ? issue_cnt_q - 1'b1 : issue_cnt_q;
    out_cnt_d    = pop ? out_cnt_q - 1'b1 : out_cnt_q;
    rd_add_d     = rd_add_q;
    if (issue) rd_add_d = (rd_add_q == STG_ITER_W'(STG_ITER_NB - 1)) ? '0 : rd_add_q + 1'b1;
    ret_d        = ROM_LATENCY'({ret_q, issue});
    inflight_d   = inflight_q;
    if (issue && !push)      inflight_d = inflight_q + 1'b1;
    else if (!issue && push) inflight_d = inflight_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_vld) begin
          issue_cnt_d = CNT_W'(cmd_pbs_nb) * CNT_W'(STG_ITER_NB);
          out_cnt_d   = CNT_W'(cmd_pbs_nb) * CNT_W'(STG_ITER_NB);
          rd_add_d    = '0;
          if (cmd_pbs_nb == '0) batch_done_d = 1'b1;
          else                  state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue && issue_cnt_q == CNT_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && out_cnt_q == CNT_W'(1)) begin
          batch_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TWD_INTT_FINAL_SEQ_FREERUN_EN
    state_d      = ST_RUN;
    batch_done_d = 1'b0;
    cmd_rdy_d    = 1'b0;
    busy_d       = 1'b1;
`else
    cmd_rdy_d    = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
`endif
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q      <= ST_IDLE;
      issue_cnt_q  <= '0;
      out_cnt_q    <= '0;
      rd_add_q     <= '0;
      inflight_q   <= '0;
      ret_q        <= '0;
      batch_done_q <= 1'b0;
      cmd_rdy_q    <= CMD_RDY_RST;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      out_cnt_q    <= out_cnt_d;
      rd_add_q     <= rd_add_d;
      inflight_q   <= inflight_d;
      ret_q        <= ret_d;
      batch_done_q <= batch_done_d;
      cmd_rdy_q    <= cmd_rdy_d;
      busy_q       <= busy_d;
    end
  end

  twiddle_intt_final_seq_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .a_rst_n   (a_rst_n),
    .push      (push),
    .push_data (rom_rd_data),
    .pop       (pop),
    .pop_data  (twd_data),
    .occ       (occ)
  );

  assign cmd_rdy    = cmd_rdy_q;
  assign busy       = busy_q;
  assign batch_done = batch_done_q;
  assign rom_rd_en  = issue;
  assign rom_rd_add = rd_add_q;

endmodule

// File: doc/twiddle_intt_final_seq.md
# twiddle_intt_final_seq

Batch-driven controller for the INTT-final twiddle ROM. It accepts one command per batch giving the number of PBS, then issues ROM reads with stage-iteration addresses in order. Returned words are buffered in a credit-controlled prefetch FIFO and presented to the NTT core over a valid/ready interface. It sits between the INTT-final twiddle ROM and the NTT core's final-multiply stage.

## Interface
- OP_W, 32, twiddle operand width
- R, 8, radix
- PSI, 8, butterflies in parallel
- S, 3, NTT stages; STG_ITER_NB = R**S / (R*PSI), STG_ITER_W = max(1, clog2(STG_ITER_NB))
- ROM_LATENCY, 1, ROM read latency in cycles (>=1)
- PBS_NB_W, 8, width of the PBS-count field
- clk  in  1  clock
- a_rst_n  in  1  reset, asynchronous, active-low
- cmd_pbs_nb  in  PBS_NB_W  PBS count for the batch
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready
- rom_rd_en  out  1  ROM read strobe
- rom_rd_add  out  STG_ITER_W  ROM address (stg_iter)
- rom_rd_data  in  PSI*R*OP_W  ROM data; valid exactly ROM_LATENCY cycles after rom_rd_en
- twd_data  out  PSI*R*OP_W  twiddle word to the NTT core
- twd_vld  out  1  twiddle valid
- twd_rdy  in  1  twiddle ready
- batch_done  out  1  one-cycle pulse when the last word of the batch is accepted
- busy  out  1  high outside IDLE

## Operation
- FSM states:
  - IDLE: cmd_rdy=1. On cmd_vld, load issue_cnt and out_cnt with cmd_pbs_nb*STG_ITER_NB, clear rd_add, then go to RUN.
  - If cmd_pbs_nb==0: no reads are issued, batch_done pulses the next cycle, and the FSM stays in IDLE.
  - RUN: issue reads while issue_cnt>0 and occ+inflight < DEPTH. When issue_cnt reaches 0, go to DRAIN.
  - DRAIN: no reads. When the final twd_vld&twd_rdy occurs, pulse batch_done and go to IDLE.
- FIFO depth DEPTH = ROM_LATENCY+2. occ counts FIFO entries; inflight counts reads issued but not yet returned. occ+inflight never exceeds DEPTH.
- Each issue sets rom_rd_en=1 with rom_rd_add=rd_add. rd_add increments and wraps from STG_ITER_NB-1 to 0, and stays continuous across PBS boundaries.
- A ROM-return shift register of ROM_LATENCY bits marks which cycles carry valid rom_rd_data. Marked data is pushed into the FIFO.
- twd_vld = (occ != 0). A pop happens on twd_vld&twd_rdy and decrements out_cnt.
- twd_data and twd_vld hold stable while twd_vld&!twd_rdy.
- Simultaneous push and pop in one cycle leaves occ unchanged.
- cmd_vld outside IDLE is ignored because cmd_rdy=0.

## Timing
- Reset values: state=IDLE, cmd_rdy=1, rom_rd_en=0, rom_rd_add=0, twd_vld=0, batch_done=0, busy=0. twd_data is don't-care.
- Command accepted at cycle T: first rom_rd_en at T+1, first twd_vld at T+2+ROM_LATENCY.
- With twd_rdy held at 1, the block sustains one word per cycle with no bubbles.
- batch_done asserts in the cycle after the last handshake. cmd_rdy rises in that same cycle.
- Reset asserted mid-batch: all counters, the FIFO and the return pipe clear immediately. In-flight ROM data is discarded.

## Configuration
- TWD_INTT_FINAL_SEQ_FREERUN_EN defined:
  - No command is needed. The FSM enters RUN from the first cycle after reset and never leaves.
  - Reads are issued indefinitely, cycling stg_iter 0..STG_ITER_NB-1.
  - cmd_rdy=0, batch_done=0, busy=1.
  - twd_vld stays 1 from its first assertion onward.
- Undefined: batch-commanded behaviour as described above.

## Structure
- pep_twd_seq_pkg holds:
  - state_e (ST_IDLE, ST_RUN, ST_DRAIN)
  - STG_ITER_NB, STG_ITER_W and DEPTH derivation functions
- One sub-module, twiddle_intt_final_seq_fifo: DEPTH-entry, PSI*R*OP_W-bit FIFO with occ output. The controller instantiates it.

## Test plan
- Default parameters (STG_ITER_NB=8), cmd_pbs_nb=3, twd_rdy=1:
  - 24 words, with stg_iter sequence 0..7 repeated 3 times.
  - Gap-free from T+3 to T+26.
  - batch_done at T+27.
- cmd_pbs_nb=2 with twd_rdy toggling 1,0,1,0:
  - 16 words in order.
  - twd_data stable while stalled.
  - occ+inflight never exceeds 3.
- ROM_LATENCY=3, cmd_pbs_nb=1, twd_rdy=0 for 20 cycles then 1:
  - Exactly 5 reads issued before the stall releases.
  - No overflow; all 8 words correct.
- cmd_pbs_nb=0 -> no rom_rd_en, batch_done pulse at T+1, cmd_rdy stays 1.
- Reset pulse asserted mid-batch after 5 words, then a new cmd_pbs_nb=1:
  - Outputs return to reset values at once.
  - The new batch starts at stg_iter 0 with no stale words.
- Freerun build with twd_rdy=1 for 1000 cycles:
  - twd_vld is never deasserted after it first rises.
  - stg_iter wraps 0..7 continuously.
